// File: rtl/sme_pkg.sv
// Shared constants, widths and FSM state type for the string-match engine.
package sme_pkg;

  localparam int STR_IW = 6;
  localparam int PAT_IW = 4;

  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_SPACE  = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMP,
    ST_ENDCHK,
    ST_DONE
  } sme_state_e;

endpackage

// File: rtl/sme_char_cmp.sv
// Single-character compare: '.' wildcard plus the word-start qualifier for '^'.
module sme_char_cmp
  import sme_pkg::*;
(
  input  logic [7:0] s_ch,
  input  logic [7:0] p_ch,
  input  logic [7:0] prev_ch,
  input  logic       chk_bound,
  input  logic       at_start,
  output logic       hit
);

  assign hit = (p_ch == CH_DOT || s_ch == p_ch) &&
               (!chk_bound || at_start || prev_ch == CH_SPACE);

endmodule

// File: rtl/sme_match_engine.sv
// Buffers string/pattern characters and scans for the first match after each pattern.
// Optional SME_EARLY_EXIT_EN stops the scan once the remaining string is shorter than the body.
module sme_match_engine
  import sme_pkg::*;
#(
  parameter int STR_DEPTH = 32,
  parameter int PAT_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        chardata,
  input  logic              isstr,
  input  logic              ispat,
  input  logic [STR_IW-1:0] str_cnt,
  input  logic [PAT_IW-1:0] pat_cnt,
  output logic              valid,
  output logic              match,
  output logic [4:0]        match_index
);

  logic [7:0] sbuf_q [STR_DEPTH];
  logic [7:0] pbuf_q [PAT_DEPTH];

  sme_state_e        state_q, state_d;
  logic [STR_IW-1:0] slen_q, slen_d, s_q, s_d;
  logic [PAT_IW-1:0] plen_q, plen_d, j_q, j_d;
  logic              ispat_dly_q, ispat_dly_d;
  logic              match_q, match_d;
  logic [4:0]        idx_q, idx_d;

  logic [STR_IW-1:0] str_wr;
  logic              pat_we;

  assign str_wr = str_cnt - 6'd1;
  assign pat_we = ispat && !isstr && !pat_cnt[3];

  // Buffers hold data across reset; slen/plen decide what is ever read.
  always_ff @(posedge clk) begin
    if (isstr && !str_wr[5]) sbuf_q[str_wr[4:0]] <= chardata;
    if (pat_we) pbuf_q[pat_cnt[2:0]] <= chardata;
  end

  logic       anch_s, anch_e;
  logic [2:0] last_idx, body_idx;
  logic [3:0] elen;

  assign last_idx = plen_q[2:0] - 3'd1;
  assign anch_s   = (plen_q != 4'd0) && (pbuf_q[0] == CH_CARET);
  assign anch_e   = (plen_q != 4'd0) && (pbuf_q[last_idx] == CH_DOLLAR);
  assign elen     = plen_q - {3'd0, anch_s} - {3'd0, anch_e};
  assign body_idx = j_q[2:0] + {2'd0, anch_s};

  logic [6:0] pos, end_pos;
  logic [4:0] s_m1;
  logic       pos_ok, cmp_hit, hit, end_ok;

  assign pos     = {1'b0, s_q} + {3'd0, j_q};
  assign end_pos = {1'b0, s_q} + {3'd0, elen};
  assign s_m1    = s_q[4:0] - 5'd1;
  assign pos_ok  = pos < {1'b0, slen_q};

  sme_char_cmp u_cmp (
    .s_ch      (sbuf_q[pos[4:0]]),
    .p_ch      (pbuf_q[body_idx]),
    .prev_ch   (sbuf_q[s_m1]),
    .chk_bound (anch_s && (j_q == 4'd0)),
    .at_start  (s_q == 6'd0),
    .hit       (cmp_hit)
  );

  assign hit    = pos_ok && cmp_hit;
  assign end_ok = !anch_e || (end_pos == {1'b0, slen_q}) ||
                  ((end_pos < {1'b0, slen_q}) && (sbuf_q[end_pos[4:0]] == CH_SPACE));

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    j_d         = j_q;
    match_d     = match_q;
    idx_d       = idx_q;
    ispat_dly_d = ispat;
    slen_d      = isstr ? str_cnt : slen_q;
    plen_d      = pat_we ? pat_cnt + 4'd1 : plen_q;

    case (state_q)
      ST_IDLE: begin
        if (ispat_dly_q && !ispat) begin
          s_d = '0;
          j_d = '0;
          if (elen == 4'd0) begin
            state_d = ST_DONE;
            match_d = 1'b0;
            idx_d   = '0;
          end else begin
            state_d = ST_CMP;
          end
        end
      end
      ST_CMP: begin
        if (isstr || ispat) begin
          state_d = ST_IDLE;
        end else if (s_q >= slen_q) begin
          state_d = ST_DONE;
          match_d = 1'b0;
          idx_d   = '0;
`ifdef SME_EARLY_EXIT_EN
        end else if ((j_q == 4'd0) && ((slen_q - s_q) < {2'd0, elen})) begin
          state_d = ST_DONE;
          match_d = 1'b0;
          idx_d   = '0;
`endif
        end else if (hit) begin
          if (j_q == elen - 4'd1) state_d = ST_ENDCHK;
          else j_d = j_q + 4'd1;
        end else begin
          s_d = s_q + 6'd1;
          j_d = '0;
        end
      end
      ST_ENDCHK: begin
        if (isstr || ispat) begin
          state_d = ST_IDLE;
        end else if (end_ok) begin
          state_d = ST_DONE;
          match_d = 1'b1;
          idx_d   = s_q[4:0];
        end else begin
          state_d = ST_CMP;
          s_d     = s_q + 6'd1;
          j_d     = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      s_q         <= '0;
      j_q         <= '0;
      slen_q      <= '0;
      plen_q      <= '0;
      ispat_dly_q <= 1'b0;
      match_q     <= 1'b0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      j_q         <= j_d;
      slen_q      <= slen_d;
      plen_q      <= plen_d;
      ispat_dly_q <= ispat_dly_d;
      match_q     <= match_d;
      idx_q       <= idx_d;
    end
  end

  assign valid       = (state_q == ST_DONE);
  assign match       = match_q;
  assign match_index = idx_q;

endmodule

// File: tb/tb_sme_match_engine.sv
// Directed scoreboard bench for sme_match_engine (expected results queued per pattern).
module tb_sme_match_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] chardata = '0;
  logic       isstr = 1'b0;
  logic       ispat = 1'b0;
  logic [5:0] str_cnt = '0;
  logic [3:0] pat_cnt = '0;
  logic       valid, match;
  logic [4:0] match_index;

  sme_match_engine dut (
    .clk         (clk),
    .rst         (rst),
    .chardata    (chardata),
    .isstr       (isstr),
    .ispat       (ispat),
    .str_cnt     (str_cnt),
    .pat_cnt     (pat_cnt),
    .valid       (valid),
    .match       (match),
    .match_index (match_index)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         m;
    logic [4:0] idx;
    int         bound;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;
  int   slen_m = 0;
  int   vcount = 0;

  always @(posedge clk) if (valid === 1'b1) vcount <= vcount + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(posedge clk); #1;
      isstr    = 1'b1;
      str_cnt  = 6'(i + 1);
      chardata = s[i];
    end
    @(posedge clk); #1;
    isstr  = 1'b0;
    slen_m = s.len();
  endtask

  task automatic send_pat(input string p);
    for (int i = 0; i < p.len(); i++) begin
      @(posedge clk); #1;
      ispat    = 1'b1;
      pat_cnt  = 4'(i);
      chardata = p[i];
    end
    @(posedge clk); #1;
    ispat = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    exp_t e;
    int   cyc = 0;
    bit   seen = 0;
    e = sb.pop_front();
    while (!seen && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (valid === 1'b1) seen = 1;
    end
    chk({tag, " valid"}, 32'(seen), 32'd1);
    chk({tag, " match"}, 32'(match), 32'(e.m));
    chk({tag, " index"}, 32'(match_index), 32'(e.idx));
    chk({tag, " latency"}, 32'(cyc <= e.bound), 32'd1);
    @(posedge clk); #1;
    chk({tag, " one-cycle valid"}, 32'(valid), 32'd0);
    chk({tag, " hold"}, 32'(match), 32'(e.m));
  endtask

  task automatic run_pat(input string p, input bit m, input int idx);
    exp_t e;
    int   elen = p.len();
    if (p.len() > 0 && p[0] == 8'h5E) elen--;
    if (p.len() > 1 && p[p.len()-1] == 8'h24) elen--;
    else if (p.len() == 1 && p[0] == 8'h24) elen--;
    e.m   = m;
    e.idx = 5'(idx);
`ifdef SME_EARLY_EXIT_EN
    e.bound = (slen_m - elen + 1) * (elen + 1) + 2;
`else
    e.bound = slen_m * (elen + 1) + 2;
`endif
    sb.push_back(e);
    send_pat(p);
    wait_result(p);
  endtask

  initial begin
    string sa;
    int    v0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset valid", 32'(valid), 32'd0);
    chk("reset match", 32'(match), 32'd0);
    chk("reset index", 32'(match_index), 32'd0);
    rst = 1'b0;

    send_str("hello world");
    run_pat("wor", 1'b1, 6);
    run_pat("^wor", 1'b1, 6);
    run_pat("^orl", 1'b0, 0);
    run_pat("lo$", 1'b1, 3);
    run_pat("wor$", 1'b0, 0);
    run_pat("h.l.o", 1'b1, 0);
    run_pat("d.", 1'b0, 0);
    run_pat("^", 1'b0, 0);

    sa = "";
    for (int i = 0; i < 31; i++) sa = {sa, "a"};
    sa = {sa, "b"};
    send_str(sa);
    run_pat("ab", 1'b1, 30);

    // Reset in the middle of a long scan.
    v0 = vcount;
    send_pat("ab");
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midscan rst valid", 32'(valid), 32'd0);
    chk("midscan rst match", 32'(match), 32'd0);
    chk("midscan rst index", 32'(match_index), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (120) @(posedge clk);
    #1;
    chk("no valid after rst", 32'(vcount - v0), 32'd0);

    // New string arriving mid-scan aborts the scan.
    send_str("hello world");
    v0 = vcount;
    send_pat("zzz");
    repeat (2) @(posedge clk);
    #1;
    send_str("xyz abc");
    repeat (40) @(posedge clk);
    #1;
    chk("no valid after abort", 32'(vcount - v0), 32'd0);
    run_pat("abc", 1'b1, 4);
    run_pat("^abc$", 1'b1, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
